// File: rtl/serial_word_adder_ctrl.sv
// Byte-serial multi-byte add/subtract sequencer around one 8-bit hybrid adder.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).

module hybridadder8_struct (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic       i_c0,
  output logic [7:0] o_s,
  output logic       o_c8
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [4:1] w_clo;
  logic [4:1] w_chi;

  // Lookahead carries inside each nibble; the nibble carry ripples between them.
  function automatic logic [4:1] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin);
    logic [4:1] c;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  assign w_g   = i_x & i_y;
  assign w_p   = i_x ^ i_y;
  assign w_clo = cla4(w_g[3:0], w_p[3:0], i_c0);
  assign w_chi = cla4(w_g[7:4], w_p[7:4], w_clo[4]);
  assign o_s   = w_p ^ {w_chi[3:1], w_clo[4], w_clo[3:1], i_c0};
  assign o_c8  = w_chi[4];
endmodule

module serial_word_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic              carry_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic              ovf,
`endif
  output logic              busy
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sub;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          r_busy;

  logic [IW+2:0] w_lsb;
  logic [7:0]    w_x;
  logic [7:0]    w_y;
  logic [7:0]    w_s;
  logic          w_c8;

  assign w_lsb = {r_idx, 3'b000};
  assign w_x   = r_a[w_lsb +: 8];
  // Subtraction is A + ~B + 1; the +1 comes from seeding the carry with op_sub.
  assign w_y   = r_b[w_lsb +: 8] ^ {8{r_sub}};

  hybridadder8_struct u_add (
    .i_x  (w_x),
    .i_y  (w_y),
    .i_c0 (r_carry),
    .o_s  (w_s),
    .o_c8 (w_c8)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  logic w_cmsb;
  assign w_cmsb = w_s[7] ^ w_x[7] ^ w_y[7];
  assign ovf    = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_sub      <= op_sub;
            r_carry    <= op_sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_lsb +: 8] <= w_s;
          r_carry           <= w_c8;
          if (r_idx == LAST) begin
            r_cout      <= w_c8;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= w_cmsb ^ w_c8;
`endif
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign busy      = r_busy;
endmodule

// File: tb/tb_serial_word_adder_ctrl.sv
// Scoreboard bench for serial_word_adder_ctrl with NBYTES=4.
module tb_serial_word_adder_ctrl;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  serial_word_adder_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, msub};
    low  = {1'b0, ma[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, msub};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = low[W-1] ^ full[W];
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                       input int hold);
    int           cnt;
    exp_t         e;
    logic [W-1:0] held;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_; op_sub = tsub; in_valid = 1'b1;
    sb.push_back(model(ta, tb_, tsub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op_sub = ~tsub;
    chk("in_ready_run", in_ready, 0);
    chk("busy_run", busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("latency", cnt, NBYTES);
    held = sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", sum, e.s);
      chk("carry_out", carry_out, e.c);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", ovf, e.v);
`endif
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("busy_idle", busy, 0);
      chk("sum_kept", sum, e.s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    do_op(32'd5, 32'd3, 1'b1, 0);
    do_op(32'd3, 32'd5, 1'b1, 0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 3);

    // Abort an operation at byte index 2.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_carry", carry_out, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NBYTES + 2; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end

    do_op(32'd1, 32'd1, 1'b0, 0);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    do_op(32'h8000_0000, 32'd1, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
